// File: rtl/ysyx_23060111_ifu_pkg.sv
// rtl/ysyx_23060111_ifu_pkg.sv - shared state encodings and constants for the fetch unit
package ysyx_23060111_ifu_pkg;

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_WB   = 3'd4
  } ifu_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060111_ifu.sv
// rtl/ysyx_23060111_ifu.sv - multi-cycle fetch unit; YSYX_23060111_IFU_MISALIGN_CHK_EN enables misaligned-fetch trapping
module ysyx_23060111_ifu
  import ysyx_23060111_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] snpc_o,
  input  logic        dnpc_valid_i,
  input  logic [31:0] dnpc_i,
  output logic        fetch_exc_o
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        exc_q, exc_d;
  logic        misalign;

`ifdef YSYX_23060111_IFU_MISALIGN_CHK_EN
  assign misalign    = (pc_q[1:0] != 2'b00);
  assign imem_addr_o = pc_q;
`else
  assign misalign    = 1'b0;
  assign imem_addr_o = {pc_q[31:2], 2'b00};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    exc_d   = exc_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ: begin
        // A misaligned PC never reaches memory; a nop is handed off with the flag instead
        if (misalign) begin
          inst_d  = NOP_INST;
          exc_d   = 1'b1;
          state_d = ST_HOLD;
        end else if (imem_req_ready_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid_i) begin
          inst_d  = imem_resp_data_i;
          exc_d   = 1'b0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (inst_ready_i) begin
          if (dnpc_valid_i) begin
            pc_d    = dnpc_i;
            state_d = ST_REQ;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        if (dnpc_valid_i) begin
          pc_d    = dnpc_i;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  assign imem_req_valid_o = (state_q == ST_REQ) && !misalign;
  assign inst_valid_o     = (state_q == ST_HOLD);
  assign inst_o           = inst_q;
  assign pc_o             = pc_q;
  assign snpc_o           = pc_q + 32'd4;
  assign fetch_exc_o      = exc_q;

endmodule

// File: tb/tb_ysyx_23060111_ifu.sv
// tb/tb_ysyx_23060111_ifu.sv - scoreboard bench for the fetch unit
module tb_ysyx_23060111_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [31:0] imem_addr_o;
  logic        imem_resp_valid_i = 1'b0;
  logic [31:0] imem_resp_data_i = 32'h0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [31:0] snpc_o;
  logic        dnpc_valid_i = 1'b0;
  logic [31:0] dnpc_i = 32'h0;
  logic        fetch_exc_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] cur_pc;
  int          n_checks = 0;
  int          n_pass = 0;

  ysyx_23060111_ifu dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_addr_o       (imem_addr_o),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .inst_valid_o      (inst_valid_o),
    .inst_ready_i      (inst_ready_i),
    .inst_o            (inst_o),
    .pc_o              (pc_o),
    .snpc_o            (snpc_o),
    .dnpc_valid_i      (dnpc_valid_i),
    .dnpc_i            (dnpc_i),
    .fetch_exc_o       (fetch_exc_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a request, accepts it and records the expected handoff.
  task automatic accept_req(input logic [31:0] data, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (imem_req_valid_o) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (ok) begin
      imem_req_ready_i = 1'b1;
      exp_q.push_back('{pc: cur_pc, inst: data});
      step();
      imem_req_ready_i = 1'b0;
    end
  endtask

  task automatic respond(input logic [31:0] data, input int lat);
    repeat (lat - 1) step();
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = data;
    step();
    imem_resp_valid_i = 1'b0;
    imem_resp_data_i  = $urandom;
  endtask

  task automatic handoff_same(input logic [31:0] next);
    inst_ready_i = 1'b1;
    dnpc_valid_i = 1'b1;
    dnpc_i       = next;
    step();
    inst_ready_i = 1'b0;
    dnpc_valid_i = 1'b0;
    cur_pc       = next;
  endtask

  task automatic handoff_wb(input int delay, input logic [31:0] next);
    inst_ready_i = 1'b1;
    step();
    inst_ready_i = 1'b0;
    repeat (delay) step();
    dnpc_valid_i = 1'b1;
    dnpc_i       = next;
    step();
    dnpc_valid_i = 1'b0;
    cur_pc       = next;
  endtask

  task automatic test_reset();
    cur_pc = RST_PC;
    repeat (2) step();
    n_checks++;
    if (imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b0 || fetch_exc_o !== 1'b0)
      $display("FAIL reset_ctrl: got req=%b iv=%b exc=%b want 0 0 0", imem_req_valid_o, inst_valid_o, fetch_exc_o);
    else n_pass++;
    n_checks++;
    if (imem_addr_o !== RST_PC || pc_o !== RST_PC || snpc_o !== RST_PC + 32'd4)
      $display("FAIL reset_pc: got addr=%h pc=%h snpc=%h want %h %h %h", imem_addr_o, pc_o, snpc_o, RST_PC, RST_PC, RST_PC + 32'd4);
    else n_pass++;
    n_checks++;
    if (inst_o !== NOP) $display("FAIL reset_inst: got %h want %h", inst_o, NOP);
    else n_pass++;
    rst_n = 1'b1;
    n_checks++;
    if (imem_req_valid_o !== 1'b0) $display("FAIL boot_cycle: got req=%b want 0", imem_req_valid_o);
    else n_pass++;
    step();
    n_checks++;
    if (imem_req_valid_o !== 1'b1 || imem_addr_o !== RST_PC)
      $display("FAIL first_req: got req=%b addr=%h want 1 %h", imem_req_valid_o, imem_addr_o, RST_PC);
    else n_pass++;
  endtask

  task automatic test_first_fetch();
    bit   ok;
    exp_t e;
    accept_req(32'h0000_0297, ok);
    n_checks++;
    if (!ok) $display("FAIL first_accept: got no request want request");
    else n_pass++;
    n_checks++;
    if (inst_valid_o !== 1'b0 || imem_req_valid_o !== 1'b0)
      $display("FAIL wait_state: got iv=%b req=%b want 0 0", inst_valid_o, imem_req_valid_o);
    else n_pass++;
    respond(32'h0000_0297, 3);
    n_checks++;
    if (inst_valid_o !== 1'b1 || exp_q.size() == 0) begin
      $display("FAIL first_hold: got iv=%b queued=%0d want 1 1", inst_valid_o, exp_q.size());
    end else begin
      n_pass++;
      e = exp_q.pop_front();
      n_checks++;
      if (inst_o !== e.inst || pc_o !== e.pc || snpc_o !== e.pc + 32'd4)
        $display("FAIL first_data: got inst=%h pc=%h snpc=%h want %h %h %h", inst_o, pc_o, snpc_o, e.inst, e.pc, e.pc + 32'd4);
      else n_pass++;
    end
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_0297 || pc_o !== RST_PC)
        $display("FAIL hold_stable: got iv=%b inst=%h pc=%h want 1 00000297 %h", inst_valid_o, inst_o, pc_o, RST_PC);
      else n_pass++;
    end
    handoff_same(32'h8000_0010);
    n_checks++;
    if (imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'h8000_0010)
      $display("FAIL same_cycle_req: got req=%b addr=%h want 1 80000010", imem_req_valid_o, imem_addr_o);
    else n_pass++;
  endtask

  task automatic test_req_stall();
    bit   ok;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'h8000_0010 || inst_valid_o !== 1'b0)
        $display("FAIL req_stable: got req=%b addr=%h iv=%b want 1 80000010 0", imem_req_valid_o, imem_addr_o, inst_valid_o);
      else n_pass++;
    end
    accept_req(32'h00a0_0093, ok);
    respond(32'h00a0_0093, 1);
    n_checks++;
    if (!ok || inst_valid_o !== 1'b1 || exp_q.size() == 0) begin
      $display("FAIL stall_hold: got ok=%b iv=%b want 1 1", ok, inst_valid_o);
    end else begin
      n_pass++;
      e = exp_q.pop_front();
      n_checks++;
      if (inst_o !== e.inst || pc_o !== e.pc || snpc_o !== e.pc + 32'd4)
        $display("FAIL stall_data: got inst=%h pc=%h snpc=%h want %h %h %h", inst_o, pc_o, snpc_o, e.inst, e.pc, e.pc + 32'd4);
      else n_pass++;
    end
    inst_ready_i = 1'b1;
    step();
    inst_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (inst_valid_o !== 1'b0 || imem_req_valid_o !== 1'b0)
        $display("FAIL wb_hold: got iv=%b req=%b want 0 0", inst_valid_o, imem_req_valid_o);
      else n_pass++;
      step();
    end
    dnpc_valid_i = 1'b1;
    dnpc_i       = 32'h8000_0100;
    step();
    dnpc_valid_i = 1'b0;
    cur_pc       = 32'h8000_0100;
    n_checks++;
    if (imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'h8000_0100)
      $display("FAIL wb_req: got req=%b addr=%h want 1 80000100", imem_req_valid_o, imem_addr_o);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit          ok;
    exp_t        e;
    logic [31:0] d;
    accept_req(32'h0000_0517, ok);
    respond(32'h0000_0517, 2);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    handoff_same(32'hFFFF_FFFC);
    n_checks++;
    if (imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC)
      $display("FAIL wrap_req: got req=%b addr=%h want 1 fffffffc", imem_req_valid_o, imem_addr_o);
    else n_pass++;
    d = $urandom;
    accept_req(d, ok);
    respond(d, 1);
    n_checks++;
    if (!ok || inst_valid_o !== 1'b1 || exp_q.size() == 0) begin
      $display("FAIL wrap_hold: got ok=%b iv=%b want 1 1", ok, inst_valid_o);
    end else begin
      n_pass++;
      e = exp_q.pop_front();
      n_checks++;
      if (inst_o !== e.inst || pc_o !== e.pc || snpc_o !== 32'h0000_0000)
        $display("FAIL wrap_snpc: got inst=%h pc=%h snpc=%h want %h %h 00000000", inst_o, pc_o, snpc_o, e.inst, e.pc);
      else n_pass++;
    end
    handoff_same(32'h8000_0200);
  endtask

  task automatic test_back_to_back();
    bit          ok;
    exp_t        e;
    logic [31:0] d;
    logic [31:0] next;
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      accept_req(d, ok);
      respond(d, int'($urandom_range(1, 4)));
      n_checks++;
      if (!ok || inst_valid_o !== 1'b1 || exp_q.size() == 0) begin
        $display("FAIL b2b_hold[%0d]: got ok=%b iv=%b want 1 1", i, ok, inst_valid_o);
      end else begin
        n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (inst_o !== e.inst || pc_o !== e.pc || snpc_o !== e.pc + 32'd4)
          $display("FAIL b2b_data[%0d]: got inst=%h pc=%h snpc=%h want %h %h %h", i, inst_o, pc_o, snpc_o, e.inst, e.pc, e.pc + 32'd4);
        else n_pass++;
      end
      next = (i == 3) ? 32'h8000_1000 : cur_pc + 32'd4;
      if (i % 2 == 0) handoff_same(next);
      else handoff_wb(i, next);
      n_checks++;
      if (imem_req_valid_o !== 1'b1 || imem_addr_o !== next)
        $display("FAIL b2b_req[%0d]: got req=%b addr=%h want 1 %h", i, imem_req_valid_o, imem_addr_o, next);
      else n_pass++;
    end
  endtask

  task automatic test_misalign();
    bit   ok;
    exp_t e;
    accept_req(32'h0000_0001, ok);
    respond(32'h0000_0001, 1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    handoff_same(32'h8000_0002);
`ifdef YSYX_23060111_IFU_MISALIGN_CHK_EN
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (imem_req_valid_o !== 1'b0) $display("FAIL misalign_noreq: got req=1 want 0");
      else n_pass++;
      if (inst_valid_o) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    n_checks++;
    if (!ok || inst_o !== NOP || fetch_exc_o !== 1'b1 || pc_o !== 32'h8000_0002)
      $display("FAIL misalign_exc: got iv=%b inst=%h exc=%b pc=%h want 1 %h 1 80000002", inst_valid_o, inst_o, fetch_exc_o, pc_o, NOP);
    else n_pass++;
    handoff_same(32'h8000_0004);
    accept_req(32'h0000_0033, ok);
    respond(32'h0000_0033, 1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    n_checks++;
    if (!ok || inst_o !== 32'h0000_0033 || fetch_exc_o !== 1'b0)
      $display("FAIL misalign_clear: got inst=%h exc=%b want 00000033 0", inst_o, fetch_exc_o);
    else n_pass++;
    handoff_same(32'h8000_0300);
`else
    n_checks++;
    if (imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'h8000_0000)
      $display("FAIL misalign_addr: got req=%b addr=%h want 1 80000000", imem_req_valid_o, imem_addr_o);
    else n_pass++;
    accept_req(32'h0000_0033, ok);
    respond(32'h0000_0033, 2);
    n_checks++;
    if (!ok || exp_q.size() == 0) begin
      $display("FAIL misalign_hold: got ok=%b want 1", ok);
    end else begin
      n_pass++;
      e = exp_q.pop_front();
      n_checks++;
      if (inst_o !== e.inst || pc_o !== e.pc || snpc_o !== 32'h8000_0006 || fetch_exc_o !== 1'b0)
        $display("FAIL misalign_data: got inst=%h pc=%h snpc=%h exc=%b want %h %h 80000006 0", inst_o, pc_o, snpc_o, fetch_exc_o, e.inst, e.pc);
      else n_pass++;
    end
    handoff_same(32'h8000_0300);
`endif
  endtask

  task automatic test_reset_in_wait();
    bit   ok;
    exp_t e;
    accept_req(32'h1234_5678, ok);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    cur_pc = RST_PC;
    n_checks++;
    if (inst_valid_o !== 1'b0 || imem_req_valid_o !== 1'b0 || pc_o !== RST_PC || imem_addr_o !== RST_PC || inst_o !== NOP)
      $display("FAIL async_reset: got iv=%b req=%b pc=%h addr=%h inst=%h want 0 0 %h %h %h", inst_valid_o, imem_req_valid_o, pc_o, imem_addr_o, inst_o, RST_PC, RST_PC, NOP);
    else n_pass++;
    step();
    rst_n = 1'b1;
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = 32'hDEAD_BEEF;
    step();
    n_checks++;
    if (imem_req_valid_o !== 1'b1 || imem_addr_o !== RST_PC || inst_valid_o !== 1'b0)
      $display("FAIL post_reset_req: got req=%b addr=%h iv=%b want 1 %h 0", imem_req_valid_o, imem_addr_o, inst_valid_o, RST_PC);
    else n_pass++;
    step();
    imem_resp_valid_i = 1'b0;
    n_checks++;
    if (inst_valid_o !== 1'b0 || inst_o !== NOP)
      $display("FAIL late_resp_ignored: got iv=%b inst=%h want 0 %h", inst_valid_o, inst_o, NOP);
    else n_pass++;
    accept_req(32'h0000_0117, ok);
    respond(32'h0000_0117, 2);
    n_checks++;
    if (!ok || inst_valid_o !== 1'b1 || exp_q.size() == 0) begin
      $display("FAIL recover_hold: got ok=%b iv=%b want 1 1", ok, inst_valid_o);
    end else begin
      n_pass++;
      e = exp_q.pop_front();
      n_checks++;
      if (inst_o !== e.inst || pc_o !== e.pc)
        $display("FAIL recover_data: got inst=%h pc=%h want %h %h", inst_o, pc_o, e.inst, e.pc);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_hold_stall();
    test_req_stall();
    test_wrap();
    test_back_to_back();
    test_misalign();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
